// File: rtl/alu_arbiter_pkg.sv
// Shared opcode encodings, flag bundle and response-stage states for the
// ALU arbiter and its combinational core.
package alu_arbiter_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    typedef struct packed {
        logic zero;
        logic carry;
        logic sign;
        logic parity;
        logic overflow;
    } flags_t;

    typedef enum logic {
        RSP_EMPTY = 1'b0,
        RSP_FULL  = 1'b1
    } rsp_state_t;

endpackage

// File: rtl/alu_arbiter_if.sv
// Request/response bundle between the issue ports and the shared ALU arbiter.
interface alu_arbiter_if #(
    parameter int NREQ = 2,
    parameter int IDW  = 2
);
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [4*NREQ-1:0] req_a;
    logic [4*NREQ-1:0] req_b;
    logic [2*NREQ-1:0] req_sel;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [IDW-1:0]    rsp_id;
    logic [3:0]        rsp_out;
    logic              rsp_zero;
    logic              rsp_carry;
    logic              rsp_sign;
    logic              rsp_parity;
    logic              rsp_overflow;
    logic [7:0]        op_count;

    modport master (
        output req_valid, req_a, req_b, req_sel, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_out, rsp_zero, rsp_carry,
               rsp_sign, rsp_parity, rsp_overflow, op_count
    );

    modport slave (
        input  req_valid, req_a, req_b, req_sel, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_out, rsp_zero, rsp_carry,
               rsp_sign, rsp_parity, rsp_overflow, op_count
    );
endinterface

// File: rtl/alu_arbiter_alu_core.sv
// Purely combinational 4-bit unsigned ALU with result flags; usable standalone.
module alu_core
    import alu_arbiter_pkg::*;
(
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic [1:0] sel,
    output logic [3:0] out,
    output flags_t     flags
);
    logic [4:0] sum;
    logic [4:0] diff;
    logic [7:0] prod;
    logic       carry;
    logic       overflow;

    always_comb begin
        sum      = {1'b0, a} + {1'b0, b};
        diff     = {1'b0, a} - {1'b0, b};
        prod     = {4'd0, a} * {4'd0, b};
        out      = 4'd0;
        carry    = 1'b0;
        overflow = 1'b0;
        case (sel)
            OP_ADD: begin
                out      = sum[3:0];
                carry    = sum[4];
                overflow = (a[3] == b[3]) && (out[3] != a[3]);
            end
            OP_SUB: begin
                out      = diff[3:0];
                carry    = (a < b);
                overflow = (a[3] != b[3]) && (out[3] != a[3]);
            end
            OP_MUL: begin
                out      = prod[3:0];
                carry    = |prod[7:4];
                overflow = |prod[7:4];
            end
            default: begin
                // Divide by zero yields 0 and reports it through carry.
                out   = (b == 4'd0) ? 4'd0 : a / b;
                carry = (b == 4'd0);
            end
        endcase
    end

    assign flags.zero     = (out == 4'd0);
    assign flags.carry    = carry;
    assign flags.sign     = out[3];
    assign flags.parity   = ^out;
    assign flags.overflow = overflow;
endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU among NREQ requesters, with a
// single-entry response register that supports same-edge pop and refill.
//
// state     | meaning
// RSP_EMPTY | no result held, a grant may be made
// RSP_FULL  | result held until rsp_valid&rsp_ready; refill only on that pop
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int IDW  = 2
)(
    input logic          clk,
    input logic          rst,
    alu_arbiter_if.slave bus
);
    rsp_state_t     state;
    rsp_state_t     state_nxt;
    logic [IDW-1:0] ptr;
    logic [IDW-1:0] hi_idx;
    logic [IDW-1:0] lo_idx;
    logic [IDW-1:0] gnt_idx;
    logic           hi_found;
    logic           lo_found;
    logic           can_take;
    logic           grant;
    logic           pop;
    logic [3:0]     a_mux;
    logic [3:0]     b_mux;
    logic [1:0]     sel_mux;
    logic [3:0]     alu_out;
    flags_t         alu_flags;
    logic [IDW-1:0] rsp_id;
    logic [3:0]     rsp_out;
    flags_t         rsp_flags;
    logic [7:0]     op_count;

    // lo_* is the lowest valid index overall, hi_* the lowest at or above ptr.
    always_comb begin
        hi_found = 1'b0;
        lo_found = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (bus.req_valid[i]) begin
                lo_found = 1'b1;
                lo_idx   = IDW'(i);
                if (IDW'(i) >= ptr) begin
                    hi_found = 1'b1;
                    hi_idx   = IDW'(i);
                end
            end
        end
    end

    assign can_take      = !rst && ((state == RSP_EMPTY) || bus.rsp_ready);
    assign grant         = can_take && (hi_found || lo_found);
    assign gnt_idx       = hi_found ? hi_idx : lo_idx;
    assign bus.req_ready = grant ? (NREQ'(1) << gnt_idx) : '0;

    always_comb begin
        a_mux   = '0;
        b_mux   = '0;
        sel_mux = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt_idx == IDW'(i)) begin
                a_mux   = bus.req_a[4*i +: 4];
                b_mux   = bus.req_b[4*i +: 4];
                sel_mux = bus.req_sel[2*i +: 2];
            end
        end
    end

    alu_core u_alu (
        .a     (a_mux),
        .b     (b_mux),
        .sel   (sel_mux),
        .out   (alu_out),
        .flags (alu_flags)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= RSP_EMPTY;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        case (state)
            RSP_EMPTY: if (grant) state_nxt = RSP_FULL;
            RSP_FULL: begin
                pop = bus.rsp_ready;
                if (pop && !grant) state_nxt = RSP_EMPTY;
            end
            default: state_nxt = RSP_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr       <= '0;
            rsp_id    <= '0;
            rsp_out   <= '0;
            rsp_flags <= '0;
            op_count  <= '0;
        end else begin
            if (grant) begin
                ptr       <= (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
                rsp_id    <= gnt_idx;
                rsp_out   <= alu_out;
                rsp_flags <= alu_flags;
            end
            if (pop) op_count <= op_count + 8'd1;
        end
    end

    assign bus.rsp_valid    = (state == RSP_FULL);
    assign bus.rsp_id       = rsp_id;
    assign bus.rsp_out      = rsp_out;
    assign bus.rsp_zero     = rsp_flags.zero;
    assign bus.rsp_carry    = rsp_flags.carry;
    assign bus.rsp_sign     = rsp_flags.sign;
    assign bus.rsp_parity   = rsp_flags.parity;
    assign bus.rsp_overflow = rsp_flags.overflow;
    assign bus.op_count     = op_count;
endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter (NREQ=2); response observed as
// {valid, id[1:0], out[3:0], zero, carry, sign, parity, overflow}.
module tb_alu_arbiter;
    import alu_arbiter_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    alu_arbiter_if #(.NREQ(2), .IDW(2)) bus ();

    alu_arbiter #(.NREQ(2), .IDW(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [11:0] obs();
        return {bus.rsp_valid, bus.rsp_id, bus.rsp_out, bus.rsp_zero, bus.rsp_carry,
                bus.rsp_sign, bus.rsp_parity, bus.rsp_overflow};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic v, input logic [3:0] a,
                           input logic [3:0] b, input logic [1:0] sel);
        bus.req_valid[i]       = v;
        bus.req_a[4*i +: 4]    = a;
        bus.req_b[4*i +: 4]    = b;
        bus.req_sel[2*i +: 2]  = sel;
    endtask

    task automatic test_reset();
        rst           = 1'b1;
        bus.rsp_ready = 1'b1;
        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.req_sel   = '0;
        set_req(0, 1'b1, 4'd2, 4'd3, OP_ADD);
        for (int c = 0; c < 2; c++) begin
            tick();
            checks++;
            if (obs() !== 12'b0) begin
                errors++; $display("FAIL reset_rsp got=%b exp=%b", obs(), 12'b0);
            end
            checks++;
            if (bus.op_count !== 8'd0) begin
                errors++; $display("FAIL reset_count got=%0d exp=0", bus.op_count);
            end
            checks++;
            if (bus.req_ready !== 2'b00) begin
                errors++; $display("FAIL reset_ready got=%b exp=00", bus.req_ready);
            end
        end
        rst = 1'b0;
        #1;
        checks++;
        if (bus.req_ready !== 2'b01) begin
            errors++; $display("FAIL release_ready got=%b exp=01", bus.req_ready);
        end
        bus.req_valid = '0;
        tick();
        checks++;
        if (bus.rsp_valid !== 1'b0) begin
            errors++; $display("FAIL idle_valid got=%b exp=0", bus.rsp_valid);
        end
    endtask

    task automatic test_single();
        set_req(1, 1'b1, 4'd9, 4'd8, OP_ADD);
        #1;
        checks++;
        if (bus.req_ready !== 2'b10) begin
            errors++; $display("FAIL single_ready got=%b exp=10", bus.req_ready);
        end
        tick();
        bus.req_valid = '0;
        checks++;
        if (obs() !== {1'b1, 2'd1, 4'd1, 5'b01011}) begin
            errors++; $display("FAIL single_rsp got=%b exp=%b", obs(), {1'b1, 2'd1, 4'd1, 5'b01011});
        end
        tick();
        checks++;
        if ({bus.rsp_valid, bus.op_count} !== {1'b0, 8'd1}) begin
            errors++; $display("FAIL single_pop got=%b/%0d exp=0/1", bus.rsp_valid, bus.op_count);
        end
    endtask

    task automatic test_fairness();
        logic [11:0] exp_obs;
        logic [1:0]  exp_rdy;
        set_req(0, 1'b1, 4'd1, 4'd1, OP_ADD);
        set_req(1, 1'b1, 4'd2, 4'd3, OP_MUL);
        for (int k = 0; k < 4; k++) begin
            #1;
            exp_rdy = (k % 2 == 1) ? 2'b10 : 2'b01;
            checks++;
            if (bus.req_ready !== exp_rdy) begin
                errors++; $display("FAIL rr_ready[%0d] got=%b exp=%b", k, bus.req_ready, exp_rdy);
            end
            tick();
            exp_obs = (k % 2 == 1) ? {1'b1, 2'd1, 4'd6, 5'b00000} : {1'b1, 2'd0, 4'd2, 5'b00010};
            checks++;
            if (obs() !== exp_obs) begin
                errors++; $display("FAIL rr_rsp[%0d] got=%b exp=%b", k, obs(), exp_obs);
            end
            checks++;
            if (bus.op_count !== 8'(1 + k)) begin
                errors++; $display("FAIL rr_count[%0d] got=%0d exp=%0d", k, bus.op_count, 1 + k);
            end
        end
        bus.req_valid = '0;
        tick();
        checks++;
        if ({bus.rsp_valid, bus.op_count} !== {1'b0, 8'd5}) begin
            errors++; $display("FAIL rr_drain got=%b/%0d exp=0/5", bus.rsp_valid, bus.op_count);
        end
    endtask

    task automatic test_backpressure();
        bus.rsp_ready = 1'b0;
        set_req(0, 1'b1, 4'd3, 4'd5, OP_SUB);
        #1;
        checks++;
        if (bus.req_ready !== 2'b01) begin
            errors++; $display("FAIL bp_first_ready got=%b exp=01", bus.req_ready);
        end
        tick();
        set_req(1, 1'b1, 4'd4, 4'd4, OP_ADD);
        checks++;
        if (obs() !== {1'b1, 2'd0, 4'd14, 5'b01110}) begin
            errors++; $display("FAIL bp_rsp got=%b exp=%b", obs(), {1'b1, 2'd0, 4'd14, 5'b01110});
        end
        for (int c = 0; c < 5; c++) begin
            #1;
            checks++;
            if (bus.req_ready !== 2'b00) begin
                errors++; $display("FAIL bp_ready[%0d] got=%b exp=00", c, bus.req_ready);
            end
            tick();
            checks++;
            if ({obs(), bus.op_count} !== {1'b1, 2'd0, 4'd14, 5'b01110, 8'd5}) begin
                errors++; $display("FAIL bp_hold[%0d] got=%b/%0d exp=%b/5", c, obs(), bus.op_count,
                                   {1'b1, 2'd0, 4'd14, 5'b01110});
            end
        end
        bus.rsp_ready = 1'b1;
        #1;
        checks++;
        if (bus.req_ready !== 2'b10) begin
            errors++; $display("FAIL bp_release_ready got=%b exp=10", bus.req_ready);
        end
        tick();
        checks++;
        if ({obs(), bus.op_count} !== {1'b1, 2'd1, 4'd8, 5'b00111, 8'd6}) begin
            errors++; $display("FAIL bp_refill got=%b/%0d exp=%b/6", obs(), bus.op_count,
                               {1'b1, 2'd1, 4'd8, 5'b00111});
        end
        bus.req_valid = '0;
        tick();
        checks++;
        if ({bus.rsp_valid, bus.op_count} !== {1'b0, 8'd7}) begin
            errors++; $display("FAIL bp_drain got=%b/%0d exp=0/7", bus.rsp_valid, bus.op_count);
        end
    endtask

    task automatic test_corners();
        set_req(0, 1'b1, 4'd7, 4'd0, OP_DIV);
        tick();
        checks++;
        if (obs() !== {1'b1, 2'd0, 4'd0, 5'b11000}) begin
            errors++; $display("FAIL div_zero got=%b exp=%b", obs(), {1'b1, 2'd0, 4'd0, 5'b11000});
        end
        set_req(0, 1'b1, 4'd5, 4'd4, OP_MUL);
        tick();
        checks++;
        if (obs() !== {1'b1, 2'd0, 4'd4, 5'b01011}) begin
            errors++; $display("FAIL mul_ovf got=%b exp=%b", obs(), {1'b1, 2'd0, 4'd4, 5'b01011});
        end
        bus.req_valid = '0;
        tick();
        checks++;
        if ({bus.rsp_valid, bus.op_count} !== {1'b0, 8'd9}) begin
            errors++; $display("FAIL corner_drain got=%b/%0d exp=0/9", bus.rsp_valid, bus.op_count);
        end
    endtask

    task automatic test_wrap_and_mid_reset();
        logic [7:0] exp_cnt;
        logic       pop;
        bit         hit255;
        bit         hit0;
        exp_cnt = 8'd9;
        hit255  = 1'b0;
        hit0    = 1'b0;
        set_req(0, 1'b1, 4'd1, 4'd2, OP_ADD);
        for (int c = 0; c < 400 && !hit0; c++) begin
            pop = bus.rsp_valid && bus.rsp_ready;
            tick();
            if (pop) exp_cnt = exp_cnt + 8'd1;
            if (exp_cnt == 8'd255 && !hit255) begin
                hit255 = 1'b1;
                checks++;
                if (bus.op_count !== 8'd255) begin
                    errors++; $display("FAIL count_255 got=%0d exp=255", bus.op_count);
                end
            end
            if (exp_cnt == 8'd0) hit0 = 1'b1;
        end
        checks++;
        if (!hit0 || bus.op_count !== 8'd0) begin
            errors++; $display("FAIL count_wrap got=%0d exp=0 reached=%0d", bus.op_count, hit0);
        end
        set_req(1, 1'b1, 4'd3, 4'd3, OP_ADD);
        #1;
        checks++;
        if (bus.req_ready !== 2'b10) begin
            errors++; $display("FAIL pre_reset_ready got=%b exp=10", bus.req_ready);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (bus.req_ready !== 2'b00) begin
            errors++; $display("FAIL mid_reset_ready got=%b exp=00", bus.req_ready);
        end
        tick();
        checks++;
        if ({obs(), bus.op_count} !== {12'b0, 8'd0}) begin
            errors++; $display("FAIL mid_reset_rsp got=%b/%0d exp=0/0", obs(), bus.op_count);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (bus.req_ready !== 2'b01) begin
            errors++; $display("FAIL post_reset_ready got=%b exp=01", bus.req_ready);
        end
        tick();
        checks++;
        if (obs() !== {1'b1, 2'd0, 4'd3, 5'b00000}) begin
            errors++; $display("FAIL post_reset_rsp got=%b exp=%b", obs(), {1'b1, 2'd0, 4'd3, 5'b00000});
        end
        bus.req_valid = '0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_fairness();
        test_backpressure();
        test_corners();
        test_wrap_and_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
